slow_clk_meter: RTL and testbench

Measures the period and high time of a slow, divided clock or strobe (`slowIn`) in cycles of the 100 MHz system clock. Results go out through a valid/ack handshake. It is the receive-side counterpart of the team's clock dividers: it checks divider outputs on the board and lets downstream logic adapt to a runtime-programmed divide ratio. It sits beside the dividers and feeds display or control logic.

---
 rtl/slow_clk_meter.sv | 211 +++++++++++++++++++++
 tb/tb_slow_clk_meter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_meter.sv
// ---------------------------------------------------------------------------
// slow_clk_meter
//
// Measures the period and high time of a slow divided clock or strobe
// (slowIn) in cycles of the 100 MHz system clock, and hands each result to a
// consumer through a valid/ack handshake.
//
// Measurement runs IDLE -> HIGH -> LOW -> HIGH ... A result is produced on
// every rising edge seen in LOW. The period is the cycle count between two
// rising edges. The high time is the count captured at the falling edge in
// between.
//
// Optional feature macro:
//   SLOW_METER_SYNC_EN - when defined, slowIn passes through a two-flop
//                        synchronizer and may be asynchronous to clk100Mhz.
//                        This adds 2 cycles of latency. When undefined,
//                        slowIn must come from the clk100Mhz domain.
//
// Parameters:
//   CNT_W      width of the measurement counter and the result buses
//
// Ports:
//   clk100Mhz  in   system clock; all state updates on its rising edge
//   reset      in   synchronous, active-high reset
//   slowIn     in   slow signal being measured
//   period     out  cycles between the last two rising edges of slowIn
//   highTime   out  cycles slowIn was high within that period
//   valid      out  a new result is held on period/highTime
//   ack        in   consumer accepts the result (meaningful while valid=1)
//   overrun    out  sticky: a result was overwritten before it was acked
//   timeout    out  sticky: the counter saturated without seeing an edge
// ---------------------------------------------------------------------------
module slow_clk_meter #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clk100Mhz,
  input  logic             reset,
  input  logic             slowIn,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] highTime,
  output logic             valid,
  input  logic             ack,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  // One below all-ones. Bumping the counter past this would wrap it, so
  // reaching this value without an edge is treated as a timeout.
  localparam logic [CNT_W-1:0] CNT_SAT = ~(CNT_W'(1));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic s;

`ifdef SLOW_METER_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= slowIn;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = slowIn;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic             sd_q;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] hi_cap_q,  hi_cap_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic [CNT_W-1:0] high_q,    high_d;
  logic             valid_q,   valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic rise;
  logic fall;
  logic sat;
  logic new_result;

  assign rise = s & ~sd_q;
  assign fall = ~s & sd_q;
  assign sat  = (cnt_q >= CNT_SAT);

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every flop samples the values from before the clock edge, whatever order
  // the statements appear in.
  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sd_q      <= 1'b0;
      cnt_q     <= '0;
      hi_cap_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sd_q      <= s;
      cnt_q     <= cnt_d;
      hi_cap_q  <= hi_cap_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every signal driven here gets a default first. Otherwise a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_cap_d   = hi_cap_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    new_result = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The first rising edge only starts counting. No result comes
        // from IDLE.
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        // The edge takes priority over saturation. Saturation only means
        // "no edge arrived in time".
        if (fall) begin
          hi_cap_d = cnt_q;
          cnt_d    = cnt_q + CNT_ONE;
          state_d  = ST_LOW;
        end else if (sat) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LOW: begin
        if (rise) begin
          new_result = 1'b1;
          period_d   = cnt_q;
          high_d     = hi_cap_q;
          cnt_d      = CNT_ONE;
          state_d    = ST_HIGH;
        end else if (sat) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake. An ack retires the held result. A new result in the same
    // cycle wins and keeps valid high. It counts as an overrun only if the
    // old result was still pending and not acked in that cycle.
    if (valid_q && ack) begin
      valid_d = 1'b0;
    end
    if (new_result) begin
      valid_d = 1'b1;
      if (valid_q && !ack) begin
        overrun_d = 1'b1;
      end
    end
  end

  assign period   = period_q;
  assign highTime = high_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_slow_clk_meter.sv
// ---------------------------------------------------------------------------
// tb_slow_clk_meter
//
// Self-checking bench for slow_clk_meter with CNT_W=8. slowIn and ack are
// driven on the falling edge, and outputs are compared on the falling edge
// after each rising edge.
//
// The reference model keeps the full history of the conditioned input. Each
// result is derived from the distance between two consecutive rising edges
// and the number of high samples between them. The handshake follows the
// valid/ack rules. Honours SLOW_METER_SYNC_EN for the input delay.
// ---------------------------------------------------------------------------
module tb_slow_clk_meter;

  localparam int CNT_W   = 8;
  localparam int MAX_CNT = (1 << CNT_W) - 1;
  localparam int HIST    = 20000;
`ifdef SLOW_METER_SYNC_EN
  localparam int SYNC_D  = 2;
  localparam int LAT     = 3;
`else
  localparam int SYNC_D  = 0;
  localparam int LAT     = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             slow_in;
  logic             ack;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             overrun;
  logic             timeout;

  slow_clk_meter #(.CNT_W(CNT_W)) dut (
    .clk100Mhz (clk),
    .reset     (reset),
    .slowIn    (slow_in),
    .period    (period),
    .highTime  (high_time),
    .valid     (valid),
    .ack       (ack),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  // Model state: input history per rising edge and the current result
  int   k        = 0;
  int   last_rst = 0;
  logic xs [0:HIST-1];
  logic sh [0:HIST-1];
  bit   m_meas   = 1'b0;
  int   m_r1     = 0;
  logic m_valid  = 1'b0;
  logic m_ovr    = 1'b0;
  logic m_to     = 1'b0;
  int   m_per    = 0;
  int   m_hi     = 0;

  // Observed-event tracking for the directed timing checks
  bit   to_seen    = 1'b0;
  int   to_edge    = -1;
  logic valid_prev = 1'b0;
  int   valid_rise = -1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (edge %0d): got %0d, expected %0d", tag, k, got, exp);
    end
  endtask

  // Conditioned input seen by the meter at rising edge kk. The synchronizer
  // delays it by SYNC_D edges and is cleared by reset.
  function automatic logic s_at(input int kk);
    if (SYNC_D == 0) return xs[kk];
    return (kk - SYNC_D > last_rst) ? xs[kk - SYNC_D] : 1'b0;
  endfunction

  function automatic logic sd_at(input int kk);
    return (kk - 1 > last_rst) ? sh[kk - 1] : 1'b0;
  endfunction

  // One system-clock cycle. ack_mode: 0 random, 1 tied high, 2 tied low,
  // 3 high exactly on the edge where a new result loads.
  task automatic step(input logic x, input int ack_mode, input logic r);
    logic s, sd, rise, a, new_res;
    int   hi;
    k++;
    xs[k] = x;
    if (r) begin
      s  = 1'b0;
      sd = 1'b0;
    end else begin
      s  = s_at(k);
      sd = sd_at(k);
    end
    sh[k]   = s;
    rise    = s & ~sd;
    new_res = !r && m_meas && rise;
    case (ack_mode)
      0:       a = 1'($urandom_range(0, 1));
      1:       a = 1'b1;
      3:       a = new_res;
      default: a = 1'b0;
    endcase

    slow_in = x;
    ack     = a;
    reset   = r;

    if (r) begin
      last_rst = k;
      m_meas   = 1'b0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_to     = 1'b0;
      m_per    = 0;
      m_hi     = 0;
      to_seen  = 1'b0;
      to_edge  = -1;
    end else if (new_res) begin
      hi = 0;
      for (int j = m_r1; j < k; j++) hi += int'(sh[j]);
      if (m_valid && !a) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_per   = k - m_r1;
      m_hi    = hi;
      m_r1    = k;
    end else begin
      if (m_valid && a) m_valid = 1'b0;
      if (m_meas) begin
        if (k - m_r1 >= MAX_CNT - 1) begin
          m_to   = 1'b1;
          m_meas = 1'b0;
        end
      end else if (rise) begin
        m_meas = 1'b1;
        m_r1   = k;
      end
    end

    @(posedge clk);
    @(negedge clk);

    check("valid",    32'(valid),     32'(m_valid));
    check("period",   32'(period),    32'(m_per));
    check("highTime", 32'(high_time), 32'(m_hi));
    check("overrun",  32'(overrun),   32'(m_ovr));
    check("timeout",  32'(timeout),   32'(m_to));

    if (timeout && !to_seen) begin
      to_seen = 1'b1;
      to_edge = k;
    end
    if (valid && !valid_prev) valid_rise = k;
    valid_prev = valid;
  endtask

  task automatic hold(input logic x, input int n, input int ack_mode);
    repeat (n) step(x, ack_mode, 1'b0);
  endtask

  task automatic wave(input int h, input int l, input int n, input int ack_mode);
    repeat (n) begin
      hold(1'b1, h, ack_mode);
      hold(1'b0, l, ack_mode);
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b0, 2, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kx;
    int kc;
    slow_in = 1'b0;
    ack     = 1'b0;
    reset   = 1'b1;
    @(negedge clk);

    // Reset state, then a symmetric divider output (5 high / 5 low) with ack
    // tied high: period 10, high time 5, valid pulses once per period.
    do_reset(2);
    hold(1'b0, 3, 2);
    wave(5, 5, 6, 1);
    check("div5_period", 32'(period),    32'd10);
    check("div5_high",   32'(high_time), 32'd5);

    // Asymmetric 3/7 with ack held low: valid stays up, overrun gets set.
    wave(3, 7, 3, 2);
    check("asym_period",  32'(period),    32'd10);
    check("asym_high",    32'(high_time), 32'd3);
    check("asym_valid",   32'(valid),     32'd1);
    check("asym_overrun", 32'(overrun),   32'd1);

    // ack in the same cycle as a new result: no overrun, valid stays high.
    do_reset(1);
    hold(1'b0, 3, 2);
    wave(4, 6, 2, 2);
    wave(4, 6, 2, 3);
    check("coinc_valid",   32'(valid),     32'd1);
    check("coinc_overrun", 32'(overrun),   32'd0);
    check("coinc_period",  32'(period),    32'd10);
    check("coinc_high",    32'(high_time), 32'd4);

    // Saturation: hold high for 300 cycles after a rising edge.
    do_reset(1);
    hold(1'b0, 4, 2);
    kx = k + 1;
    hold(1'b1, 300, 2);
    check("timeout_delay", 32'(to_edge - (kx + SYNC_D)), 32'd254);
    wave(5, 5, 3, 1);
    check("after_to_period", 32'(period),  32'd10);
    check("after_to_sticky", 32'(timeout), 32'd1);

    // Reset in the middle of the LOW phase.
    do_reset(1);
    hold(1'b0, 2, 2);
    wave(5, 5, 2, 1);
    hold(1'b1, 5, 1);
    hold(1'b0, 2, 1);
    step(1'b0, 1, 1'b1);
    check("midrst_valid",  32'(valid),  32'd0);
    check("midrst_period", 32'(period), 32'd0);
    hold(1'b0, 3, 1);
    wave(5, 5, 3, 1);

    // Latency from the completing rising edge to valid.
    do_reset(1);
    hold(1'b0, 4, 2);
    wave(6, 6, 1, 2);
    valid_rise = -1;
    kc = k + 1;
    hold(1'b1, 6, 2);
    check("latency", 32'(valid_rise - kc + 1), 32'(LAT));

    // Randomized waveforms and ack patterns.
    do_reset(1);
    hold(1'b0, 3, 0);
    repeat (30) begin
      wave(int'($urandom_range(2, 12)), int'($urandom_range(2, 12)), 1, 0);
    end
    hold(1'b0, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
